virt_trap_sequencer: RTL and testbench

- Clocked sequencer for Z80 virtualization on the Nabu MegaMapper CPLD.
- Tracks whether the CPU runs the virtualized program (virtual_mode=1) or the supervisor ISR (virtual_mode=0).
- On a trap it pulses NMI, then drives override_address through the NMI acknowledge and the vector fetch at 0x0066.
- It returns to virtual mode after the supervisor executes its final jump.

---
 rtl/virt_trap_sequencer.sv | 224 ++++++++++++++++++++++
 tb/tb_virt_trap_sequencer.sv | 290 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/virt_trap_sequencer.sv
// Z80 virtualization trap sequencer: tracks virtual/supervisor context, pulses NMI on a trap
// and steers the NMI ack and 0x0066 vector fetch. Optional ACK watchdog: VIRT_TRAP_ACK_TIMEOUT_EN.
module virt_trap_sequencer #(
    parameter int unsigned NMI_PULSE = 4
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    ,
    parameter int unsigned ACK_TIMEOUT = 255
`endif
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_trap_condition,
    input  logic       i_irq_n,
    input  logic       i_m1_n,
    input  logic       i_new_isr,
    input  logic       i_last_isr_jmp,
    output logic       o_virtual_mode,
    output logic       o_nmi_n,
    output logic       o_override_address,
    output logic [1:0] o_trap_cause
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    ,
    output logic       o_nmi_retry_err
`endif
);

    typedef enum logic [2:0] {
        ST_SUPER,
        ST_EXIT,
        ST_VIRT,
        ST_NMI,
        ST_ACK,
        ST_VECT,
        ST_FETCH
    } state_t;

    localparam logic [3:0] NMI_LOAD = 4'(NMI_PULSE - 1);
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    localparam logic [7:0] ACK_LAST = 8'(ACK_TIMEOUT - 1);
`endif

    // Two-flop synchronizers; active-low lines idle high so reset creates no false edge.
    logic [1:0] r_m1_sync;
    logic [1:0] r_trap_sync;
    logic [1:0] r_irq_sync;
    logic [1:0] r_new_isr_sync;
    logic [1:0] r_last_jmp_sync;
    logic       r_m1_prev;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_nmi_cnt;
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    logic [7:0] r_ack_cnt;
    logic       r_nmi_retry_err;
`endif

    logic       r_virtual_mode;
    logic       r_nmi_n;
    logic       r_override_address;
    logic [1:0] r_trap_cause;

    logic       w_virtual_mode_nxt;
    logic       w_nmi_n_nxt;
    logic       w_override_nxt;
    logic [1:0] w_trap_cause_nxt;

    logic       w_m1;
    logic       w_m1_fall;
    logic       w_m1_rise;
    logic       w_trap;
    logic       w_irq_req;
    logic       w_last_jmp;
    logic       w_enter_nmi;

    assign w_m1       = r_m1_sync[1];
    assign w_m1_fall  = r_m1_prev & ~w_m1;
    assign w_m1_rise  = ~r_m1_prev & w_m1;
    assign w_trap     = r_trap_sync[1];
    assign w_irq_req  = r_new_isr_sync[1] & ~r_irq_sync[1];
    assign w_last_jmp = r_last_jmp_sync[1];
    assign w_enter_nmi = (w_state_nxt == ST_NMI) && (r_state != ST_NMI);

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples the
    // pre-edge value of every other flop regardless of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_m1_sync          <= 2'b11;
            r_trap_sync        <= 2'b00;
            r_irq_sync         <= 2'b11;
            r_new_isr_sync     <= 2'b00;
            r_last_jmp_sync    <= 2'b00;
            r_m1_prev          <= 1'b1;
            r_state            <= ST_SUPER;
            r_nmi_cnt          <= 4'd0;
            r_virtual_mode     <= 1'b0;
            r_nmi_n            <= 1'b1;
            r_override_address <= 1'b0;
            r_trap_cause       <= 2'b00;
        end else begin
            r_m1_sync          <= {r_m1_sync[0], i_m1_n};
            r_trap_sync        <= {r_trap_sync[0], i_trap_condition};
            r_irq_sync         <= {r_irq_sync[0], i_irq_n};
            r_new_isr_sync     <= {r_new_isr_sync[0], i_new_isr};
            r_last_jmp_sync    <= {r_last_jmp_sync[0], i_last_isr_jmp};
            r_m1_prev          <= w_m1;
            r_state            <= w_state_nxt;
            r_virtual_mode     <= w_virtual_mode_nxt;
            r_nmi_n            <= w_nmi_n_nxt;
            r_override_address <= w_override_nxt;
            r_trap_cause       <= w_trap_cause_nxt;
            if (w_enter_nmi) begin
                r_nmi_cnt <= NMI_LOAD;
            end else if ((r_state == ST_NMI) && (r_nmi_cnt != 4'd0)) begin
                r_nmi_cnt <= r_nmi_cnt - 4'd1;
            end
        end
    end

`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    // ACK watchdog: counts clocks spent waiting for the acknowledge M1.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_ack_cnt       <= 8'd0;
            r_nmi_retry_err <= 1'b0;
        end else begin
            if (r_state == ST_ACK) begin
                r_ack_cnt <= r_ack_cnt + 8'd1;
            end else begin
                r_ack_cnt <= 8'd0;
            end
            if ((r_state == ST_ACK) && (w_state_nxt == ST_NMI)) begin
                r_nmi_retry_err <= 1'b1;
            end
        end
    end
`endif

    // NOTE: every always_comb target gets a default first, so no path can infer a latch.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_SUPER: begin
                if (w_m1_fall && w_last_jmp) begin
                    w_state_nxt = ST_EXIT;
                end
            end
            ST_EXIT: begin
                if (w_m1_fall) begin
                    w_state_nxt = ST_VIRT;
                end
            end
            ST_VIRT: begin
                if (w_trap || w_irq_req) begin
                    w_state_nxt = ST_NMI;
                end
            end
            ST_NMI: begin
                if (r_nmi_cnt == 4'd0) begin
                    w_state_nxt = ST_ACK;
                end
            end
            ST_ACK: begin
                if (w_m1_fall) begin
                    w_state_nxt = ST_VECT;
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
                end else if (r_ack_cnt == ACK_LAST) begin
                    w_state_nxt = ST_NMI;
`endif
                end
            end
            ST_VECT: begin
                if (w_m1_fall) begin
                    w_state_nxt = ST_FETCH;
                end
            end
            ST_FETCH: begin
                if (w_m1_rise) begin
                    w_state_nxt = ST_SUPER;
                end
            end
            default: w_state_nxt = ST_SUPER;
        endcase
    end

    // Outputs are decoded from the next state and registered, so they move on the transition edge.
    always_comb begin
        w_virtual_mode_nxt = 1'b0;
        w_nmi_n_nxt        = 1'b1;
        w_override_nxt     = 1'b0;
        w_trap_cause_nxt   = r_trap_cause;
        case (w_state_nxt)
            ST_VIRT, ST_ACK: begin
                w_virtual_mode_nxt = 1'b1;
            end
            ST_NMI: begin
                w_virtual_mode_nxt = 1'b1;
                w_nmi_n_nxt        = 1'b0;
            end
            ST_VECT: begin
                w_virtual_mode_nxt = 1'b1;
                w_override_nxt     = 1'b1;
            end
            ST_FETCH: begin
                w_override_nxt = 1'b1;
            end
            default: begin
                w_virtual_mode_nxt = 1'b0;
            end
        endcase
        if ((r_state == ST_VIRT) && (w_state_nxt == ST_NMI)) begin
            w_trap_cause_nxt = w_trap ? 2'b01 : 2'b10;
        end
    end

    assign o_virtual_mode     = r_virtual_mode;
    assign o_nmi_n            = r_nmi_n;
    assign o_override_address = r_override_address;
    assign o_trap_cause       = r_trap_cause;
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    assign o_nmi_retry_err    = r_nmi_retry_err;
`endif

endmodule

// File: tb/tb_virt_trap_sequencer.sv
// Self-checking bench for virt_trap_sequencer: vector table, hand sequences and randomized
// trap episodes whose expected waveforms come from the 3-clock latency and M1 sequencing rules.
module tb_virt_trap_sequencer;

    logic       clk;
    logic       rst;
    logic       trap_condition;
    logic       irq_n;
    logic       m1_n;
    logic       new_isr;
    logic       last_isr_jmp;
    logic       virtual_mode;
    logic       nmi_n;
    logic       override_address;
    logic [1:0] trap_cause;
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
    logic       nmi_retry_err;
`endif

    int total = 0;
    int bad = 0;
    logic [1:0] model_cause;

    virt_trap_sequencer #(
        .NMI_PULSE(4)
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
        ,
        .ACK_TIMEOUT(16)
`endif
    ) dut (
        .i_clk              (clk),
        .i_rst              (rst),
        .i_trap_condition   (trap_condition),
        .i_irq_n            (irq_n),
        .i_m1_n             (m1_n),
        .i_new_isr          (new_isr),
        .i_last_isr_jmp     (last_isr_jmp),
        .o_virtual_mode     (virtual_mode),
        .o_nmi_n            (nmi_n),
        .o_override_address (override_address),
        .o_trap_cause       (trap_cause)
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
        ,
        .o_nmi_retry_err    (nmi_retry_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1);
    end

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic vm, input logic nmi, input logic ovr);
        check({tag, ".vm"}, 8'(virtual_mode), 8'(vm));
        check({tag, ".nmi"}, 8'(nmi_n), 8'(nmi));
        check({tag, ".ovr"}, 8'(override_address), 8'(ovr));
    endtask

    task automatic hold(input int n, input string tag, input logic vm, input logic nmi, input logic ovr);
        for (int i = 0; i < n; i++) begin
            tick();
            chk_out(tag, vm, nmi, ovr);
        end
    endtask

    task automatic idle_inputs();
        trap_condition = 1'b0;
        irq_n          = 1'b1;
        m1_n           = 1'b1;
        new_isr        = 1'b0;
        last_isr_jmp   = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_cause = 2'b00;
        chk_out("reset", 1'b0, 1'b1, 1'b0);
        check("reset.cause", 8'(trap_cause), 8'h00);
`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
        check("reset.retry_err", 8'(nmi_retry_err), 8'h00);
`endif
    endtask

    // SUPER -> EXIT -> VIRT; optional trap/irq noise in SUPER that must be ignored.
    task automatic exit_to_virt(input int noise);
        if (noise > 0) begin
            trap_condition = 1'b1;
            new_isr        = 1'b1;
            irq_n          = 1'b0;
            hold(noise, "super_ignore", 1'b0, 1'b1, 1'b0);
            trap_condition = 1'b0;
            new_isr        = 1'b0;
            irq_n          = 1'b1;
        end
        last_isr_jmp = 1'b1;
        m1_n = 1'b0;
        hold(3, "exit_jmp", 1'b0, 1'b1, 1'b0);
        last_isr_jmp = 1'b0;
        m1_n = 1'b1;
        hold(2, "exit_operands", 1'b0, 1'b1, 1'b0);
        m1_n = 1'b0;
        hold(2, "exit_pre", 1'b0, 1'b1, 1'b0);
        tick();
        chk_out("exit_vm", 1'b1, 1'b1, 1'b0);
        m1_n = 1'b1;
    endtask

    // From VIRT: apply a request; nmi_n low on clocks 3..6 after it, cause latched on clock 3.
    task automatic nmi_pulse(input logic t, input logic ni, input logic iq);
        logic [1:0] exp_c;
        exp_c = t ? 2'b01 : 2'b10;
        trap_condition = t;
        new_isr        = ni;
        irq_n          = iq;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_out("pulse", 1'b1, (i >= 3) ? 1'b0 : 1'b1, 1'b0);
            check("pulse.cause", 8'(trap_cause), 8'((i >= 3) ? exp_c : model_cause));
            if (i == 3) begin
                trap_condition = 1'b0;
                new_isr        = 1'b0;
                irq_n          = 1'b1;
            end
        end
        model_cause = exp_c;
    endtask

    // From the first ACK clock: ack M1 (override 3 clocks after fall), vector fetch M1
    // (virtual_mode drops 3 clocks after fall), override released 3 clocks after its rise.
    task automatic ack_fetch(input int ack_wait, input int lo1, input int hi1, input int lo2);
        tick();
        chk_out("ack_enter", 1'b1, 1'b1, 1'b0);
        hold(ack_wait, "ack_wait", 1'b1, 1'b1, 1'b0);
        m1_n = 1'b0;
        for (int i = 1; i <= lo1 + hi1; i++) begin
            tick();
            chk_out("ack_m1", 1'b1, 1'b1, (i >= 3) ? 1'b1 : 1'b0);
            if (i == lo1) m1_n = 1'b1;
        end
        m1_n = 1'b0;
        for (int i = 1; i <= lo2 + 4; i++) begin
            tick();
            chk_out("vect_m1", (i >= 3) ? 1'b0 : 1'b1, 1'b1, (i < lo2 + 3) ? 1'b1 : 1'b0);
            if (i == lo2) m1_n = 1'b1;
        end
        check("fetch.cause_kept", 8'(trap_cause), 8'(model_cause));
    endtask

    typedef struct {
        string name;
        logic  trap;
        logic  new_isr;
        logic  irq_n;
        logic  fires;
        logic [1:0] cause;
    } vec_t;

    vec_t vecs[5];

    initial begin
        vecs[0] = '{"trap_only",   1'b1, 1'b0, 1'b1, 1'b1, 2'b01};
        vecs[1] = '{"trap_and_irq",1'b1, 1'b1, 1'b0, 1'b1, 2'b01};
        vecs[2] = '{"irq_only",    1'b0, 1'b1, 1'b0, 1'b1, 2'b10};
        vecs[3] = '{"isr_no_irq",  1'b0, 1'b1, 1'b1, 1'b0, 2'b00};
        vecs[4] = '{"irq_no_isr",  1'b0, 1'b0, 1'b0, 1'b0, 2'b00};

        idle_inputs();
        rst = 1'b1;
        model_cause = 2'b00;
        tick();
        do_reset();

        // SUPER ignores trap and irq while waiting for the exit jump.
        exit_to_virt(6);

        // last_isr_jmp with M1 activity during VIRT changes nothing.
        last_isr_jmp = 1'b1;
        for (int i = 0; i < 8; i++) begin
            m1_n = i[0];
            tick();
            chk_out("virt_jmp_ignore", 1'b1, 1'b1, 1'b0);
        end
        idle_inputs();
        hold(3, "virt_idle", 1'b1, 1'b1, 1'b0);

        for (int v = 0; v < 5; v++) begin
            if (vecs[v].fires) begin
                nmi_pulse(vecs[v].trap, vecs[v].new_isr, vecs[v].irq_n);
                check({vecs[v].name, ".cause"}, 8'(trap_cause), 8'(vecs[v].cause));
                ack_fetch(2, 2, 2, 2);
                exit_to_virt(0);
            end else begin
                trap_condition = vecs[v].trap;
                new_isr        = vecs[v].new_isr;
                irq_n          = vecs[v].irq_n;
                hold(6, vecs[v].name, 1'b1, 1'b1, 1'b0);
                check({vecs[v].name, ".cause"}, 8'(trap_cause), 8'(model_cause));
                idle_inputs();
                hold(3, vecs[v].name, 1'b1, 1'b1, 1'b0);
            end
        end

        // Randomized episodes: harmless VIRT noise, a random request, random M1 timing.
        for (int e = 0; e < 20; e++) begin
            int n;
            int sel;
            n = int'($urandom_range(0, 4));
            for (int i = 0; i < n; i++) begin
                m1_n         = 1'($urandom);
                last_isr_jmp = 1'($urandom);
                if (($urandom & 1) != 0) begin
                    new_isr = 1'b1;
                    irq_n   = 1'b1;
                end else begin
                    new_isr = 1'b0;
                    irq_n   = 1'b0;
                end
                tick();
                chk_out("rand_noise", 1'b1, 1'b1, 1'b0);
            end
            idle_inputs();
            sel = int'($urandom_range(1, 3));
            nmi_pulse(sel[0], sel[1], ~sel[1]);
            ack_fetch(int'($urandom_range(0, 6)), int'($urandom_range(1, 3)),
                      int'($urandom_range(2, 4)), int'($urandom_range(1, 4)));
            exit_to_virt(int'($urandom_range(0, 3)));
        end

        // Reset on the second clock of the NMI pulse.
        trap_condition = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_out("midrst_pulse", 1'b1, (i >= 3) ? 1'b0 : 1'b1, 1'b0);
        end
        trap_condition = 1'b0;
        do_reset();
        hold(4, "midrst_after", 1'b0, 1'b1, 1'b0);
        exit_to_virt(0);

`ifdef VIRT_TRAP_ACK_TIMEOUT_EN
        // No ack M1: retry pulse starts 16 clocks after ACK entry; error is sticky.
        nmi_pulse(1'b1, 1'b0, 1'b1);
        for (int i = 7; i <= 27; i++) begin
            tick();
            chk_out("timeout", 1'b1, ((i >= 23) && (i <= 26)) ? 1'b0 : 1'b1, 1'b0);
            check("timeout.retry_err", 8'(nmi_retry_err), 8'((i >= 23) ? 1 : 0));
            check("timeout.cause", 8'(trap_cause), 8'h01);
        end
        m1_n = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            tick();
            chk_out("timeout_ack", 1'b1, 1'b1, (i >= 3) ? 1'b1 : 1'b0);
            if (i == 2) m1_n = 1'b1;
        end
        m1_n = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            tick();
            chk_out("timeout_vect", (i >= 3) ? 1'b0 : 1'b1, 1'b1, (i < 5) ? 1'b1 : 1'b0);
            if (i == 2) m1_n = 1'b1;
        end
        exit_to_virt(0);
        check("retry_err.sticky", 8'(nmi_retry_err), 8'h01);
        do_reset();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
